sr_responder: RTL and testbench

SR_RESPONDER -- requirements
Module: sr_responder

---
 rtl/sr_responder_pkg.sv | 14 +
 rtl/sr_responder_if.sv | 21 ++
 rtl/sr_sync_edge.sv | 32 +++
 rtl/sr_responder.sv | 123 ++++++++++++
 tb/tb_sr_responder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/sr_responder_pkg.sv
// Shared definitions for the serial configuration responder and its controller.
// FSM state type and the default word/counter sizes both sides agree on.
package sr_responder_pkg;

  localparam int unsigned SrWidth    = 170;
  localparam int unsigned SrCntWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLoad
  } sr_state_e;

endpackage

// File: rtl/sr_responder_if.sv
// Serial link between the configuration controller and the responder.
interface sr_responder_if;
  logic sr_clk;
  logic sr_din;
  logic sr_load;
  logic sr_dout;

  modport master (
    output sr_clk,
    output sr_din,
    output sr_load,
    input  sr_dout
  );

  modport slave (
    input  sr_clk,
    input  sr_din,
    input  sr_load,
    output sr_dout
  );
endinterface

// File: rtl/sr_sync_edge.sv
// Two-flop synchronizer with history flop and registered rising-edge pulse.
// level_o is delayed to stay aligned with rise_o.
module sr_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic sync1_q, sync2_q, hist_q, level_q, rise_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      level_q <= sync2_q;
      rise_q  <= sync2_q & ~hist_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/sr_responder.sv
// Serial configuration responder: shifts config in on sr_clk, latches it on sr_load.
// Optional bit-count check enabled by defining SR_RESPONDER_CNT_CHECK_EN.
module sr_responder
  import sr_responder_pkg::*;
#(
  parameter int unsigned WIDTH           = SrWidth,
  parameter int unsigned CNT_WIDTH       = SrCntWidth,
  parameter bit          SHIFT_DIRECTION = 1'b1
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  sr_responder_if.slave        sr,
  output logic [WIDTH-1:0]     cfg_q,
  output logic                 cfg_valid,
  output logic [CNT_WIDTH-1:0] bit_count,
  output logic                 busy,
  output logic                 cnt_err
);

  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  logic clk_lvl, clk_rise, din_lvl, din_rise, load_lvl, load_rise;
  logic unused_lvl;

  sr_sync_edge u_sync_clk (
    .clk_i  (clk_in),
    .rst_ni (rst_n),
    .d_i    (sr.sr_clk),
    .level_o(clk_lvl),
    .rise_o (clk_rise)
  );

  sr_sync_edge u_sync_din (
    .clk_i  (clk_in),
    .rst_ni (rst_n),
    .d_i    (sr.sr_din),
    .level_o(din_lvl),
    .rise_o (din_rise)
  );

  sr_sync_edge u_sync_load (
    .clk_i  (clk_in),
    .rst_ni (rst_n),
    .d_i    (sr.sr_load),
    .level_o(load_lvl),
    .rise_o (load_rise)
  );

  assign unused_lvl = clk_lvl ^ din_rise ^ load_lvl;

  logic [WIDTH-1:0]     sreg_q, sreg_d, sreg_shifted;
  logic [WIDTH-1:0]     cfg_word_q, cfg_word_d;
  logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d, cnt_incl;
  sr_state_e            state_q, state_d;

  if (SHIFT_DIRECTION) begin : g_msb_first
    assign sreg_shifted = {sreg_q[WIDTH-2:0], din_lvl};
    assign sr.sr_dout   = sreg_q[WIDTH-1];
  end else begin : g_lsb_first
    assign sreg_shifted = {din_lvl, sreg_q[WIDTH-1:1]};
    assign sr.sr_dout   = sreg_q[0];
  end

  // A shift coinciding with a load is applied first and counted before the clear.
  always_comb begin
    sreg_d   = clk_rise ? sreg_shifted : sreg_q;
    cnt_incl = bit_cnt_q;
    if (clk_rise && (bit_cnt_q != CntMax)) begin
      cnt_incl = bit_cnt_q + 1'b1;
    end
    bit_cnt_d  = load_rise ? '0 : cnt_incl;
    cfg_word_d = load_rise ? sreg_d : cfg_word_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load_rise) state_d = StLoad;
               else if (clk_rise) state_d = StShift;
      StShift: if (load_rise) state_d = StLoad;
      StLoad:  if (load_rise) state_d = StLoad;
               else if (clk_rise) state_d = StShift;
               else state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q     <= '0;
      cfg_word_q <= '0;
      bit_cnt_q  <= '0;
      state_q    <= StIdle;
    end else begin
      sreg_q     <= sreg_d;
      cfg_word_q <= cfg_word_d;
      bit_cnt_q  <= bit_cnt_d;
      state_q    <= state_d;
    end
  end

`ifdef SR_RESPONDER_CNT_CHECK_EN
  logic cnt_err_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_err_q <= 1'b0;
    end else if (load_rise) begin
      cnt_err_q <= (cnt_incl != CNT_WIDTH'(WIDTH));
    end
  end

  assign cnt_err = cnt_err_q;
`else
  assign cnt_err = 1'b0;
`endif

  assign cfg_q     = cfg_word_q;
  assign bit_count = bit_cnt_q;
  assign busy      = (state_q == StShift);
  assign cfg_valid = (state_q == StLoad);

endmodule

// File: tb/tb_sr_responder.sv
// Directed bench for sr_responder: MSB-first and LSB-first instances driven side by side.
module tb_sr_responder;

  localparam int W = 170;
  localparam int CW = 8;

  logic clk_in = 1'b0;
  logic rst_n;
  always #5 clk_in = ~clk_in;

  sr_responder_if sr1 ();
  sr_responder_if sr0 ();

  logic [W-1:0]  cfg1, cfg0;
  logic          val1, val0, busy1, busy0, err1, err0;
  logic [CW-1:0] cnt1, cnt0;

  sr_responder #(.WIDTH(W), .CNT_WIDTH(CW), .SHIFT_DIRECTION(1'b1)) dut1 (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .sr       (sr1.slave),
    .cfg_q    (cfg1),
    .cfg_valid(val1),
    .bit_count(cnt1),
    .busy     (busy1),
    .cnt_err  (err1)
  );

  sr_responder #(.WIDTH(W), .CNT_WIDTH(CW), .SHIFT_DIRECTION(1'b0)) dut0 (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .sr       (sr0.slave),
    .cfg_q    (cfg0),
    .cfg_valid(val0),
    .bit_count(cnt0),
    .busy     (busy0),
    .cnt_err  (err0)
  );

  int total = 0;
  int bad = 0;
  int vcnt1 = 0;
  int vcnt0 = 0;
  logic [W-1:0] rb1, rb0;

  always @(negedge clk_in) begin
    if (val1) vcnt1++;
    if (val0) vcnt0++;
  end

  typedef struct {
    logic [W-1:0] data;
    int           nbits;
    logic [W-1:0] exp_cfg;
    logic [W-1:0] exp_rb;
    logic         exp_err;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic c, input logic d, input logic l);
    sr1.sr_clk = c; sr1.sr_din = d; sr1.sr_load = l;
    sr0.sr_clk = c; sr0.sr_din = d; sr0.sr_load = l;
  endtask

  // Readback is sampled just before each rising sr_clk, as the controller would.
  task automatic send_bit(input logic b, input logic with_load);
    drive(1'b0, b, 1'b0);
    tick(3);
    rb1 = {rb1[W-2:0], sr1.sr_dout};
    rb0 = {sr0.sr_dout, rb0[W-1:1]};
    drive(1'b1, b, with_load);
    tick(6);
    drive(1'b0, b, 1'b0);
    tick(3);
  endtask

  task automatic send_msb(input logic [W-1:0] data, input int n, input logic same_load);
    rb1 = '0; rb0 = '0;
    for (int i = n - 1; i >= 0; i--) send_bit(data[i], same_load && (i == 0));
    tick(3);
  endtask

  task automatic send_lsb(input logic [W-1:0] data);
    rb1 = '0; rb0 = '0;
    for (int i = 0; i < W; i++) send_bit(data[i], 1'b0);
    tick(3);
  endtask

  task automatic do_load();
    vcnt1 = 0; vcnt0 = 0;
    drive(1'b0, 1'b0, 1'b1);
    tick(6);
    drive(1'b0, 1'b0, 1'b0);
    tick(6);
  endtask

  logic [W-1:0] p0, p1, p2, pa, pb, mask;
  logic         err_on;

  initial begin
`ifdef SR_RESPONDER_CNT_CHECK_EN
    err_on = 1'b1;
`else
    err_on = 1'b0;
`endif
    p0 = {85{2'b10}};
    p1 = {2'b00, {21{8'h0F}}};
    p2 = {10{17'h12345}};
    pa = p0 ^ p2;
    pb = p0 ^ p1;
    tbl[0] = '{data: p0, nbits: 170, exp_cfg: p0, exp_rb: '0, exp_err: 1'b0};
    tbl[1] = '{data: p1, nbits: 170, exp_cfg: p1, exp_rb: p0, exp_err: 1'b0};
    tbl[2] = '{data: p2, nbits: 169, exp_cfg: {p1[0], p2[168:0]}, exp_rb: p1, exp_err: 1'b1};
    tbl[3] = '{data: p0, nbits: 170, exp_cfg: p0, exp_rb: {p1[0], p2[168:0]}, exp_err: 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tick(3);
    chk("rst_cfg_q", cfg1, '0);
    chk("rst_bit_count", W'(cnt1), '0);
    chk("rst_busy", W'(busy1), '0);
    chk("rst_cfg_valid", W'(val1), '0);
    chk("rst_sr_dout", W'(sr1.sr_dout), '0);
    chk("rst_cnt_err", W'(err1), '0);
    rst_n = 1'b1;
    tick(3);

    for (int r = 0; r < 4; r++) begin
      send_msb(tbl[r].data, tbl[r].nbits, 1'b0);
      mask = {W{1'b1}} >> (W - tbl[r].nbits);
      chk($sformatf("row%0d_readback", r), rb1 & mask, tbl[r].exp_rb >> (W - tbl[r].nbits));
      chk($sformatf("row%0d_bit_count", r), W'(cnt1), W'(tbl[r].nbits));
      chk($sformatf("row%0d_busy", r), W'(busy1), W'(1'b1));
      do_load();
      chk($sformatf("row%0d_cfg_q", r), cfg1, tbl[r].exp_cfg);
      chk($sformatf("row%0d_cnt_err", r), W'(err1), W'(tbl[r].exp_err & err_on));
      chk($sformatf("row%0d_valid_pulses", r), W'(vcnt1), W'(1));
      chk($sformatf("row%0d_idle", r), W'(busy1), '0);
      chk($sformatf("row%0d_count_clr", r), W'(cnt1), '0);
    end

    // Load rising on the same sample as the 170th sr_clk rise.
    vcnt1 = 0;
    send_msb(p1, 170, 1'b1);
    tick(6);
    chk("same_cfg_q", cfg1, p1);
    chk("same_cnt_err", W'(err1), '0);
    chk("same_valid_pulses", W'(vcnt1), W'(1));
    chk("same_count_clr", W'(cnt1), '0);
    chk("same_readback", rb1, p0);

    // LSB-first instance starting from a clean reset.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    send_lsb(pa);
    do_load();
    chk("lsb_cfg_q", cfg0, pa);
    chk("lsb_readback_zero", rb0, '0);
    chk("lsb_valid_pulses", W'(vcnt0), W'(1));
    send_lsb(p1);
    do_load();
    chk("lsb_readback", rb0, pa);
    chk("lsb_cfg_q2", cfg0, p1);
    chk("lsb_cnt_err", W'(err0), '0);

    // Reset in the middle of a word discards the partial shift.
    send_msb(p2, 80, 1'b0);
    chk("mid_count80", W'(cnt1), W'(80));
    rst_n = 1'b0;
    tick(2);
    chk("mid_rst_count", W'(cnt1), '0);
    chk("mid_rst_cfg", cfg1, '0);
    chk("mid_rst_dout", W'(sr1.sr_dout), '0);
    chk("mid_rst_busy", W'(busy1), '0);
    rst_n = 1'b1;
    tick(3);
    send_msb(pb, 170, 1'b0);
    chk("post_rst_count", W'(cnt1), W'(170));
    chk("post_rst_readback", rb1, '0);
    do_load();
    chk("post_rst_cfg_q", cfg1, pb);
    chk("post_rst_cnt_err", W'(err1), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
